// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Instruction memory loader / fetch controller with LOAD, RUN and
//               HALT modes. Optional macro HALT_ON_ZERO_EN makes a fetched
//               16'h0000 word halt the core.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] LOAD_BASE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_done,
    output logic        load_ready,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [15:0] pc_out,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic [1:0]  state_out,
    output logic        load_overflow,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] c_ST_LOAD = 2'b00;
    localparam logic [1:0] c_ST_RUN  = 2'b01;
    localparam logic [1:0] c_ST_HALT = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  w_state_eff;
    logic [15:0] r_load_ptr;
    logic [15:0] w_load_ptr_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic        r_load_overflow;
    logic        w_load_overflow_nxt;
    logic [15:0] r_fetch_count;
    logic [15:0] w_fetch_count_nxt;
    logic        w_zero_halt;

`ifdef HALT_ON_ZERO_EN
    assign w_zero_halt = !stall && (mem_rdata == 16'h0000);
`else
    assign w_zero_halt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_LOAD;
            r_load_ptr      <= LOAD_BASE;
            r_pc            <= RESET_PC;
            r_load_overflow <= 1'b0;
            r_fetch_count   <= 16'h0000;
        end else begin
            r_state         <= w_state_nxt;
            r_load_ptr      <= w_load_ptr_nxt;
            r_pc            <= w_pc_nxt;
            r_load_overflow <= w_load_overflow_nxt;
            r_fetch_count   <= w_fetch_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_load_ptr_nxt      = r_load_ptr;
        w_pc_nxt            = r_pc;
        w_load_overflow_nxt = r_load_overflow;
        w_fetch_count_nxt   = r_fetch_count;
        case (r_state)
            c_ST_LOAD: begin
                // A word offered alongside load_done is still stored.
                if (load_valid) begin
                    w_load_ptr_nxt = r_load_ptr + 16'd1;
                    if (r_load_ptr == 16'hFFFF) begin
                        w_load_overflow_nxt = 1'b1;
                    end
                end
                if (load_done) begin
                    w_state_nxt = c_ST_RUN;
                    w_pc_nxt    = RESET_PC;
                end
            end
            c_ST_RUN: begin
                if (halt_req || w_zero_halt) begin
                    w_state_nxt = c_ST_HALT;
                end else if (!stall) begin
                    w_pc_nxt = branch_taken ? branch_target : (r_pc + 16'd1);
                    if (r_fetch_count != 16'hFFFF) begin
                        w_fetch_count_nxt = r_fetch_count + 16'd1;
                    end
                end
            end
            c_ST_HALT: begin
                if (resume && !halt_req) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = c_ST_LOAD;
            end
        endcase
    end

    // Outputs look like LOAD while reset is asserted, whatever the current state.
    assign w_state_eff = rst ? c_ST_LOAD : r_state;

    always_comb begin
        load_ready  = 1'b0;
        mem_addr    = r_pc;
        mem_we      = 1'b0;
        mem_wdata   = 16'h0000;
        instr_out   = 16'h0000;
        instr_valid = 1'b0;
        case (w_state_eff)
            c_ST_LOAD: begin
                load_ready = 1'b1;
                mem_addr   = r_load_ptr;
                mem_we     = load_valid;
                mem_wdata  = load_data;
            end
            c_ST_RUN: begin
                instr_out   = mem_rdata;
                instr_valid = !stall;
            end
            default: begin
            end
        endcase
    end

    assign pc_out        = r_pc;
    assign state_out     = w_state_eff;
    assign load_overflow = r_load_overflow;
    assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Self-checking bench for imem_fetch_ctrl against a behavioural
//               model; honours HALT_ON_ZERO_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam logic [15:0] c_RP  = 16'h0000;
    localparam logic [15:0] c_LB  = 16'h0000;
    localparam logic [15:0] c_LB2 = 16'hFFFF;

    logic        clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        r_load_valid = 1'b0;
    logic [15:0] r_load_data = 16'h0000;
    logic        r_load_done = 1'b0;
    logic        r_stall = 1'b0;
    logic        r_branch_taken = 1'b0;
    logic [15:0] r_branch_target = 16'h0000;
    logic        r_halt_req = 1'b0;
    logic        r_resume = 1'b0;

    logic        w_load_ready, w_mem_we, w_instr_valid, w_load_overflow;
    logic [15:0] w_mem_addr, w_mem_wdata, w_mem_rdata, w_pc_out, w_instr_out, w_fetch_count;
    logic [1:0]  w_state_out;
    logic        w_load_ready2, w_mem_we2, w_instr_valid2, w_load_overflow2;
    logic [15:0] w_mem_addr2, w_mem_wdata2, w_mem_rdata2, w_pc_out2, w_instr_out2, w_fetch_count2;
    logic [1:0]  w_state_out2;

    bit [15:0] ram  [0:65535];
    bit [15:0] ram2 [0:65535];
    bit [15:0] exp_mem [0:65535];

    int total = 0;
    int bad   = 0;

    int          m_state;
    int          m_ptr, m_ptr2, m_pc, m_cnt;
    logic        m_ovf, m_ovf2;
    logic [15:0] words [0:2];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.RESET_PC(c_RP), .LOAD_BASE(c_LB)) dut (
        .clk(clk), .rst(r_rst), .load_valid(r_load_valid), .load_data(r_load_data),
        .load_done(r_load_done), .load_ready(w_load_ready), .mem_addr(w_mem_addr),
        .mem_we(w_mem_we), .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata),
        .stall(r_stall), .branch_taken(r_branch_taken), .branch_target(r_branch_target),
        .halt_req(r_halt_req), .resume(r_resume), .pc_out(w_pc_out),
        .instr_out(w_instr_out), .instr_valid(w_instr_valid), .state_out(w_state_out),
        .load_overflow(w_load_overflow), .fetch_count(w_fetch_count)
    );

    imem_fetch_ctrl #(.RESET_PC(c_RP), .LOAD_BASE(c_LB2)) dut2 (
        .clk(clk), .rst(r_rst), .load_valid(r_load_valid), .load_data(r_load_data),
        .load_done(r_load_done), .load_ready(w_load_ready2), .mem_addr(w_mem_addr2),
        .mem_we(w_mem_we2), .mem_wdata(w_mem_wdata2), .mem_rdata(w_mem_rdata2),
        .stall(r_stall), .branch_taken(r_branch_taken), .branch_target(r_branch_target),
        .halt_req(r_halt_req), .resume(r_resume), .pc_out(w_pc_out2),
        .instr_out(w_instr_out2), .instr_valid(w_instr_valid2), .state_out(w_state_out2),
        .load_overflow(w_load_overflow2), .fetch_count(w_fetch_count2)
    );

    assign w_mem_rdata  = ram[w_mem_addr];
    assign w_mem_rdata2 = ram2[w_mem_addr2];

    always @(posedge clk) begin
        if (w_mem_we)  ram[w_mem_addr]   <= w_mem_wdata;
        if (w_mem_we2) ram2[w_mem_addr2] <= w_mem_wdata2;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = int'(c_LB);
        m_ptr2  = int'(c_LB2);
        m_pc    = int'(c_RP);
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_ovf2  = 1'b0;
    endtask

    // Expected outputs from the model state and the inputs currently applied.
    task automatic check_outputs();
        int eff;
        eff = r_rst ? 0 : m_state;
        check("state_out", 16'(w_state_out), 16'(eff));
        check("load_ready", 16'(w_load_ready), 16'(eff == 0));
        check("instr_valid", 16'(w_instr_valid), 16'(eff == 1 && !r_stall));
        check("mem_we", 16'(w_mem_we), 16'(eff == 0 && r_load_valid));
        check("load_overflow", 16'(w_load_overflow), 16'(m_ovf));
        check("load_overflow_b2", 16'(w_load_overflow2), 16'(m_ovf2));
        check("fetch_count", w_fetch_count, 16'(m_cnt));
        if (eff == 0) begin
            check("mem_addr_load", w_mem_addr, 16'(m_ptr));
            check("mem_addr_load_b2", w_mem_addr2, 16'(m_ptr2));
            check("instr_out_load", w_instr_out, 16'h0000);
            if (r_load_valid) check("mem_wdata", w_mem_wdata, r_load_data);
        end else begin
            check("pc_out", w_pc_out, 16'(m_pc));
            check("mem_addr_fetch", w_mem_addr, 16'(m_pc));
            check("instr_out", w_instr_out, (eff == 1) ? exp_mem[m_pc] : 16'h0000);
        end
    endtask

    task automatic model_update();
        logic zero_halt;
        zero_halt = 1'b0;
`ifdef HALT_ON_ZERO_EN
        zero_halt = !r_stall && (exp_mem[m_pc] == 16'h0000);
`endif
        if (r_rst) begin
            model_reset();
        end else if (m_state == 0) begin
            if (r_load_valid) begin
                exp_mem[m_ptr] = r_load_data;
                if (m_ptr == 65535) m_ovf = 1'b1;
                if (m_ptr2 == 65535) m_ovf2 = 1'b1;
                m_ptr  = (m_ptr + 1) % 65536;
                m_ptr2 = (m_ptr2 + 1) % 65536;
            end
            if (r_load_done) begin
                m_state = 1;
                m_pc    = int'(c_RP);
            end
        end else if (m_state == 1) begin
            if (r_halt_req || zero_halt) m_state = 2;
            else if (!r_stall) begin
                m_pc  = r_branch_taken ? int'(r_branch_target) : (m_pc + 1) % 65536;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end else begin
            if (r_resume && !r_halt_req) m_state = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        r_load_valid = 1'b0; r_load_done = 1'b0; r_stall = 1'b0;
        r_branch_taken = 1'b0; r_halt_req = 1'b0; r_resume = 1'b0;
    endtask

    task automatic rand_run(input int n, input int tmax);
        for (int i = 0; i < n; i++) begin
            r_stall         = ($urandom_range(99, 0) < 25);
            r_branch_taken  = ($urandom_range(99, 0) < 20);
            r_branch_target = ($urandom_range(99, 0) < 5) ? 16'hFFFF : 16'($urandom_range(tmax, 0));
            r_halt_req      = ($urandom_range(99, 0) < 5);
            r_resume        = ($urandom_range(99, 0) < 30);
            r_load_valid    = $urandom_range(1, 0) == 1;
            r_load_data     = 16'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        r_rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        tick();
        tick();
        r_rst = 1'b0;

        // Three-word program A,B,C; the last word arrives with load_done.
        for (int k = 0; k < 3; k++) words[k] = 16'($urandom_range(65535, 1));
        for (int k = 0; k < 3; k++) begin
            r_load_valid = 1'b1;
            r_load_data  = words[k];
            r_load_done  = (k == 2);
            tick();
            if (k == 0) begin
                r_load_valid = 1'b0;
                tick();
            end
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) check("ram_word", 16'(ram[k]), words[k]);
        check("ram_b2_ffff", 16'(ram2[16'hFFFF]), words[0]);
        check("ram_b2_0000", 16'(ram2[0]), words[1]);
        check("overflow_b2", 16'(w_load_overflow2), 16'h0001);
        for (int k = 0; k < 3; k++) begin
            check("pc_seq", w_pc_out, 16'(k));
            check("instr_seq", w_instr_out, words[k]);
            tick();
        end
        check("fetch_count_3", w_fetch_count, 16'd3);

        // Branch to 5, stalled branch held off, then taken.
        r_branch_taken = 1'b1; r_branch_target = 16'h0005; tick();
        r_stall = 1'b1; r_branch_target = 16'h0100; tick();
        check("pc_stall_hold", w_pc_out, 16'h0005);
        r_stall = 1'b0; tick();
        r_branch_taken = 1'b0;
        check("pc_branch", w_pc_out, 16'h0100);
        tick();

        // Halt at pc 7, simultaneous halt_req+resume stays halted, then resume.
        r_branch_taken = 1'b1; r_branch_target = 16'h0007; tick();
        r_branch_taken = 1'b1; r_branch_target = 16'h0020; r_halt_req = 1'b1; tick();
        r_branch_taken = 1'b0;
        r_resume = 1'b1; tick();
        r_halt_req = 1'b0; r_resume = 1'b0; tick();
        check("halt_pc", w_pc_out, 16'h0007);
        check("halt_state", 16'(w_state_out), 16'h0002);
        r_resume = 1'b1; tick();
        r_resume = 1'b0; tick();

        // PC wrap at the top of the address space.
        r_branch_taken = 1'b1; r_branch_target = 16'hFFFF; tick();
        r_branch_taken = 1'b0; tick();
        tick();

        rand_run(400, 8);

        // Reset while loading the second word.
        r_rst = 1'b1; tick();
        r_rst = 1'b0;
        r_load_valid = 1'b1; r_load_data = 16'h1234; tick();
        r_load_data = 16'h5678; r_rst = 1'b1; tick();
        r_rst = 1'b0; r_load_valid = 1'b0; tick();
        check("ptr_after_rst", w_mem_addr, c_LB);

        // Random image, then random execution over it.
        for (int i = 0; i < 40; i++) begin
            r_load_valid = ($urandom_range(99, 0) < 60);
            r_load_data  = ($urandom_range(99, 0) < 10) ? 16'h0000 : 16'($urandom);
            tick();
        end
        r_load_valid = 1'b1; r_load_data = 16'($urandom_range(65535, 1)); r_load_done = 1'b1;
        tick();
        idle_inputs();
        rand_run(400, 47);

        // Program A,0000: zero word halts only when the option is built in.
        r_rst = 1'b1; tick();
        r_rst = 1'b0;
        r_load_valid = 1'b1; r_load_data = 16'hA5A5; tick();
        r_load_data = 16'h0000; r_load_done = 1'b1; tick();
        idle_inputs();
        for (int k = 0; k < 4; k++) tick();
`ifdef HALT_ON_ZERO_EN
        check("zero_halt_pc", w_pc_out, 16'h0001);
`else
        check("zero_run_pc", w_pc_out, 16'h0004);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
